// File: rtl/risc24_pkg.sv
// Shared types and constants for the multicycle core's LM/SM sequencer.
// Holds the sequencer state enum, datapath widths and the register index type.
package risc24_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;

  typedef logic [2:0] reg_idx_t;

  // R0 holds the PC and is never moved by LM/SM.
  localparam reg_idx_t PC_REG = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Mask with the bit at position idx cleared.
  function automatic logic [NREG-1:0] clear_bit(input logic [NREG-1:0] vec, input reg_idx_t idx);
    logic [NREG-1:0] r;
    r      = vec;
    r[idx] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Bundle of request, register-file and data-memory signals of the LM/SM sequencer.
// The master side is the sequencer; the slave side is control FSM + RF + memory.
interface lmsm_sequencer_if;
  import risc24_pkg::*;

  // Handshake: start is a one-cycle request honoured only while busy is low;
  // it is not queued. done pulses for exactly one cycle when the walk completes,
  // and busy stays high from the cycle after acceptance through the done cycle.
  logic            start;
  logic            is_lm;
  logic [NREG-1:0] mask;
  logic [DW-1:0]   base_addr;

  reg_idx_t        rf_ra;
  logic [DW-1:0]   rf_rd;
  reg_idx_t        rf_wa;
  logic [DW-1:0]   rf_wd;
  logic            rf_we;

  logic [DW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;

  logic            busy;
  logic            done;
  state_e          dbg_state;

  modport master (
    input  start, is_lm, mask, base_addr, rf_rd, mem_rdata,
    output rf_ra, rf_wa, rf_wd, rf_we, mem_addr, mem_wdata, mem_we,
    output busy, done, dbg_state
  );

  modport slave (
    output start, is_lm, mask, base_addr, rf_rd, mem_rdata,
    input  rf_ra, rf_wa, rf_wd, rf_we, mem_addr, mem_wdata, mem_we,
    input  busy, done, dbg_state
  );

endinterface

// File: rtl/lmsm_sequencer_prio_enc8.sv
// 8-bit lowest-set-bit encoder; idx is 0 when no bit is set (any=0).
module prio_enc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = 3'd0;
    any = |vec;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask, one RF<->memory transfer
// per cycle at consecutive addresses, then pulses done.
module lmsm_sequencer
  import risc24_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  lmsm_sequencer_if.master   bus
);

  state_e          state_q, state_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   last_addr_q, last_addr_d;
  logic            op_lm_q, op_lm_d;
  reg_idx_t        ra_q, ra_d;
  reg_idx_t        wa_q, wa_d;

  reg_idx_t        idx;
  logic            pend_any;
  logic [NREG-1:0] pend_clr;
  logic [NREG-1:0] eff_mask;
  logic            in_run;
  logic            xfer;

  prio_enc8 u_pick (
    .vec (pend_q),
    .idx (idx),
    .any (pend_any)
  );

  assign pend_clr = clear_bit(pend_q, idx);
  assign eff_mask = clear_bit(bus.mask, PC_REG);
  assign in_run   = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    op_lm_d     = op_lm_q;
    ra_d        = ra_q;
    wa_d        = wa_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pend_d  = eff_mask;
          addr_d  = bus.base_addr;
          op_lm_d = bus.is_lm;
          state_d = (|eff_mask) ? RUN : DONE;
        end
      end
      RUN: begin
        if (pend_any) begin
          pend_d      = pend_clr;
          addr_d      = addr_q + DW'(1);
          last_addr_d = addr_q;
          if (op_lm_q) wa_d = idx;
          else         ra_d = idx;
          if (pend_clr == '0) state_d = DONE;
        end else begin
          // Unreachable with a consistent pend; recover rather than stall.
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      op_lm_q     <= 1'b0;
      ra_q        <= '0;
      wa_q        <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      op_lm_q     <= op_lm_d;
      ra_q        <= ra_d;
      wa_q        <= wa_d;
    end
  end

  // Strobes are gated by reset so a transfer in the reset cycle never commits.
  assign xfer = in_run && pend_any && !reset;

  assign bus.rf_we     = xfer && op_lm_q;
  assign bus.mem_we    = xfer && !op_lm_q;
  assign bus.rf_wa     = (in_run && op_lm_q)  ? idx : wa_q;
  assign bus.rf_ra     = (in_run && !op_lm_q) ? idx : ra_q;
  assign bus.mem_addr  = in_run ? addr_q : last_addr_q;
  assign bus.rf_wd     = bus.mem_rdata;
  assign bus.mem_wdata = bus.rf_rd;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: RF/memory models, expected-transfer queue
// drained by a negedge monitor, plus per-operation timing checks.
module tb_lmsm_sequencer;
  import risc24_pkg::*;

  logic clk;
  logic reset;

  lmsm_sequencer_if bus();

  lmsm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment models
  logic [15:0] rf_m  [0:7];
  logic [15:0] mem_m [0:65535];

  assign bus.rf_rd     = rf_m[bus.rf_ra];
  assign bus.mem_rdata = mem_m[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.rf_we)  rf_m[bus.rf_wa]     <= bus.rf_wd;
    if (bus.mem_we) mem_m[bus.mem_addr] <= bus.mem_wdata;
  end

  // scoreboard: {kind[1:0], addr[15:0], data[15:0]}; kind 1=RF write, 2=MEM write, 3=done
  logic [33:0] exp_q[$];
  int total;
  int bad;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] act;
    logic [33:0] e;
    if (bus.rf_we || bus.mem_we) check("strobe_exclusive", {32'd0, bus.rf_we, bus.mem_we}, {32'd0, bus.rf_we, !bus.rf_we});
    if (bus.rf_we || bus.mem_we || bus.done) begin
      if (bus.rf_we)       act = {2'd1, 13'd0, bus.rf_wa, bus.rf_wd};
      else if (bus.mem_we) act = {2'd2, bus.mem_addr, bus.mem_wdata};
      else                 act = {2'd3, 32'd0};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", act, e);
      end
    end
  end

  // driver
  task automatic run_op(input bit lm, input logic [7:0] m, input logic [15:0] base, input bit repulse);
    int n, done_cyc, dn_cnt, busy_cnt, we_cnt, wrong_cnt;
    bit fin;
    logic [15:0] a;
    n = 0; a = base;
    for (int i = 1; i < 8; i++) begin
      if (m[i]) begin
        if (lm) exp_q.push_back({2'd1, 13'd0, 3'(i), mem_m[a]});
        else    exp_q.push_back({2'd2, a, rf_m[i]});
        a = a + 16'd1;
        n++;
      end
    end
    exp_q.push_back({2'd3, 32'd0});
    @(posedge clk); #1;
    bus.is_lm = lm; bus.mask = m; bus.base_addr = base; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.is_lm = 1'($urandom_range(0, 1));
    bus.mask = 8'($urandom_range(0, 255));
    bus.base_addr = 16'($urandom_range(0, 65535));
    done_cyc = 0; dn_cnt = 0; busy_cnt = 0; we_cnt = 0; wrong_cnt = 0; fin = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        dn_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (bus.busy) busy_cnt++;
      if (lm ? bus.rf_we : bus.mem_we) we_cnt++;
      if (lm ? bus.mem_we : bus.rf_we) wrong_cnt++;
      bus.start = repulse && (cyc == 1 || bus.done);
      if (done_cyc != 0 && cyc > done_cyc) begin
        fin = 1;
        break;
      end
    end
    bus.start = 1'b0;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done within 40 cycles expected done at %0d", n + 1);
      exp_q.delete();
    end else begin
      check("done_cycle", 34'(done_cyc), 34'(n + 1));
      check("done_pulses", 34'(dn_cnt), 34'd1);
      check("busy_cycles", 34'(busy_cnt), 34'(n + 1));
      check("xfer_cycles", 34'(we_cnt), 34'(n));
      check("wrong_strobe", 34'(wrong_cnt), 34'd0);
      check("queue_drained", 34'(exp_q.size()), 34'd0);
      check("idle_after", {32'd0, bus.busy, bus.done}, 34'd0);
    end
  endtask

  // stimulus
  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_lm = 1'b0; bus.mask = '0; bus.base_addr = '0;
    rf_m[0] <= 16'h0BAD; rf_m[1] <= 16'h1111; rf_m[2] <= 16'h2222; rf_m[3] <= 16'h3333;
    rf_m[4] <= 16'h4444; rf_m[5] <= 16'h5555; rf_m[6] <= 16'h6666; rf_m[7] <= 16'h7777;
    for (int i = 0; i < 7; i++) mem_m[16'h0010 + i] <= 16'hA0 + 16'(i);
    for (int i = 0; i < 7; i++) mem_m[16'h0040 + i] <= 16'hB1 + 16'(i);
    mem_m[16'h0500] <= 16'hCAFE;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy",     {33'd0, bus.busy},   34'd0);
    check("rst_done",     {33'd0, bus.done},   34'd0);
    check("rst_rf_we",    {33'd0, bus.rf_we},  34'd0);
    check("rst_mem_we",   {33'd0, bus.mem_we}, 34'd0);
    check("rst_rf_ra",    34'(bus.rf_ra),      34'd0);
    check("rst_rf_wa",    34'(bus.rf_wa),      34'd0);
    check("rst_mem_addr", 34'(bus.mem_addr),   34'd0);
    check("rst_state",    34'(bus.dbg_state),  34'(IDLE));

    // SM R1,R3,R5 to 0x0100..
    run_op(1'b0, 8'h2A, 16'h0100, 1'b0);
    check("sm_mem100", 34'(mem_m[16'h0100]), 34'h1111);
    check("sm_mem101", 34'(mem_m[16'h0101]), 34'h3333);
    check("sm_mem102", 34'(mem_m[16'h0102]), 34'h5555);

    // LM all registers from 0x0010; R0 untouched
    run_op(1'b1, 8'hFF, 16'h0010, 1'b0);
    check("lm_r0", 34'(rf_m[0]), 34'h0BAD);
    check("lm_r1", 34'(rf_m[1]), 34'h00A0);
    check("lm_r4", 34'(rf_m[4]), 34'h00A3);
    check("lm_r7", 34'(rf_m[7]), 34'h00A6);

    // empty effective masks
    run_op(1'b0, 8'h01, 16'h0500, 1'b0);
    run_op(1'b1, 8'h00, 16'h0500, 1'b0);
    check("empty_mem500", 34'(mem_m[16'h0500]), 34'hCAFE);
    check("empty_r0",     34'(rf_m[0]),         34'h0BAD);

    // address wrap
    run_op(1'b0, 8'h0E, 16'hFFFE, 1'b0);
    check("wrap_fffe", 34'(mem_m[16'hFFFE]), 34'h00A0);
    check("wrap_ffff", 34'(mem_m[16'hFFFF]), 34'h00A1);
    check("wrap_0000", 34'(mem_m[16'h0000]), 34'h00A2);

    // reset after the second LM transfer
    exp_q.push_back({2'd1, 13'd0, 3'd1, 16'h00B1});
    exp_q.push_back({2'd1, 13'd0, 3'd2, 16'h00B2});
    @(posedge clk); #1;
    bus.is_lm = 1'b1; bus.mask = 8'hFE; bus.base_addr = 16'h0040; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rr_busy",  {33'd0, bus.busy},  34'd0);
    check("rr_rf_we", {33'd0, bus.rf_we}, 34'd0);
    check("rr_done",  {33'd0, bus.done},  34'd0);
    check("rr_queue", 34'(exp_q.size()),  34'd0);
    check("rr_r1",    34'(rf_m[1]),       34'h00B1);
    check("rr_r2",    34'(rf_m[2]),       34'h00B2);
    check("rr_r3",    34'(rf_m[3]),       34'h00A2);
    exp_q.delete();
    run_op(1'b0, 8'h06, 16'h0300, 1'b0);
    check("rr_mem300", 34'(mem_m[16'h0300]), 34'h00B1);
    check("rr_mem301", 34'(mem_m[16'h0301]), 34'h00B2);

    // start re-pulsed in RUN and in DONE is ignored
    run_op(1'b0, 8'h2A, 16'h0200, 1'b1);
    check("rp_mem200", 34'(mem_m[16'h0200]), 34'h00B1);
    check("rp_mem201", 34'(mem_m[16'h0201]), 34'h00A2);
    check("rp_mem202", 34'(mem_m[16'h0202]), 34'h00A4);
    repeat (3) @(negedge clk);
    check("rp_no_restart", {33'd0, bus.busy}, 34'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
